// File: rtl/uart_pkg.sv
// Shared UART constants: reference-clock accumulator, receiver state encoding, LCR field widths.
package uart_pkg;

  localparam int unsigned CNT_ADD = 576;
  localparam int unsigned CNT_MAX = 15625;
  localparam int unsigned ACC_W   = 15;
  localparam int unsigned DIV_W   = 16;
  localparam int unsigned WLS_W   = 2;
  localparam int unsigned DATA_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  // Index of the last data bit for a word-length select (0..3 -> 5..8 bits).
  function automatic logic [2:0] wls_last_bit(input logic [WLS_W-1:0] wls);
    return 3'd4 + 3'(wls);
  endfunction

endpackage

// File: rtl/uart_rx_16x_if.sv
// CPU-side register interface of the receiver: divisor/LCR controls, read strobes and LSR/RBR status.
interface uart_rx_16x_if;
  import uart_pkg::*;

  logic [DIV_W-1:0]  divisor;
  logic [WLS_W-1:0]  lcr_wls;
  logic              lcr_pen;
  logic              lcr_eps;
  logic              rbr_rd;
  logic              lsr_rd;
  logic [DATA_W-1:0] rbr;
  logic              dr;
  logic              oe;
  logic              pe;
  logic              fe;
  logic              bi;

  modport master (
    output divisor, lcr_wls, lcr_pen, lcr_eps, rbr_rd, lsr_rd,
    input  rbr, dr, oe, pe, fe, bi
  );

  modport slave (
    input  divisor, lcr_wls, lcr_pen, lcr_eps, rbr_rd, lsr_rd,
    output rbr, dr, oe, pe, fe, bi
  );

endinterface

// File: rtl/uart_baud_tick.sv
// 1.8432 MHz reference enable from a fractional accumulator, divided by the divisor latch into a 16x tick.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CNT_ADD = uart_pkg::CNT_ADD,
  parameter int unsigned CNT_MAX = uart_pkg::CNT_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] divisor,
  output logic             s_tick
);

  localparam logic [ACC_W-1:0] STEP    = ACC_W'(CNT_ADD);
  localparam logic [ACC_W-1:0] MODULUS = ACC_W'(CNT_MAX);
  localparam logic [ACC_W-1:0] WRAP_AT = ACC_W'(CNT_MAX - CNT_ADD);

  logic [ACC_W-1:0] acc;
  logic [DIV_W-1:0] div_cnt;
  logic             ref_tick;

  assign ref_tick = (acc >= WRAP_AT);
  // A counter at 0 or 1 reloads, so the divisor is picked up on the first reference tick after enable.
  assign s_tick   = ref_tick && (divisor != '0) && (div_cnt <= DIV_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      div_cnt <= '0;
    end else begin
      acc <= ref_tick ? acc + STEP - MODULUS : acc + STEP;
      if (divisor == '0)
        div_cnt <= '0;
      else if (ref_tick)
        div_cnt <= (div_cnt <= DIV_W'(1)) ? divisor : div_cnt - DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_16x.sv
// 8250-style receiver: 16x oversampled deserialiser into RBR with LSR dr/oe/pe/fe/bi status.
module uart_rx_16x
  import uart_pkg::*;
#(
  parameter int unsigned CNT_ADD     = uart_pkg::CNT_ADD,
  parameter int unsigned CNT_MAX     = uart_pkg::CNT_MAX,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          clk_50m,
  input  logic          rst,
  input  logic          rxd,
  uart_rx_16x_if.slave  bus
);

  logic                   s_tick;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rxd_s;

  rx_state_t         state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic [2:0]        bitcnt, bitcnt_n;
  logic [DATA_W-1:0] data, data_n;
  logic              pbit, pbit_n;
  logic              perr, perr_n;
  logic              commit;
  logic              brk;

  logic [DATA_W-1:0] rbr;
  logic              dr, oe, pe, fe, bi;

  uart_baud_tick #(
    .CNT_ADD (CNT_ADD),
    .CNT_MAX (CNT_MAX)
  ) u_baud (
    .clk     (clk_50m),
    .rst     (rst),
    .divisor (bus.divisor),
    .s_tick  (s_tick)
  );

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) sync <= '1;
    else     sync <= {sync[SYNC_STAGES-2:0], rxd};
  end
  assign rxd_s = sync[SYNC_STAGES-1];

  // pbit is cleared at frame start, so with parity disabled it never masks a break.
  assign brk = (data == '0) && !pbit && !rxd_s;

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      bitcnt <= '0;
      data   <= '0;
      pbit   <= 1'b0;
      perr   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      bitcnt <= bitcnt_n;
      data   <= data_n;
      pbit   <= pbit_n;
      perr   <= perr_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bitcnt_n = bitcnt;
    data_n   = data;
    pbit_n   = pbit;
    perr_n   = perr;
    commit   = 1'b0;
    if (bus.divisor == '0) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: if (!rxd_s) begin
          state_n = START;
          cnt_n   = '0;
        end
        START: if (s_tick) begin
          if (cnt == 4'd7) begin
            if (rxd_s) begin
              state_n = IDLE;
            end else begin
              state_n  = DATA;
              cnt_n    = '0;
              bitcnt_n = '0;
              data_n   = '0;
              pbit_n   = 1'b0;
              perr_n   = 1'b0;
            end
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
        DATA: if (s_tick) begin
          cnt_n = cnt + 4'd1;
          if (cnt == 4'd15) begin
            data_n[bitcnt] = rxd_s;
            if (bitcnt == wls_last_bit(bus.lcr_wls))
              state_n = bus.lcr_pen ? PARITY : STOP;
            else
              bitcnt_n = bitcnt + 3'd1;
          end
        end
        PARITY: if (s_tick) begin
          cnt_n = cnt + 4'd1;
          if (cnt == 4'd15) begin
            pbit_n  = rxd_s;
            perr_n  = ((^data) ^ rxd_s) != ~bus.lcr_eps;
            state_n = STOP;
          end
        end
        STOP: if (s_tick) begin
          cnt_n = cnt + 4'd1;
          if (cnt == 4'd15) begin
            commit  = 1'b1;
            state_n = brk ? WAIT_HIGH : IDLE;
          end
        end
        WAIT_HIGH: if (rxd_s) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // A read coinciding with a commit consumes the old character, so dr stays set and no overrun is flagged.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      rbr <= '0;
      dr  <= 1'b0;
      oe  <= 1'b0;
      pe  <= 1'b0;
      fe  <= 1'b0;
      bi  <= 1'b0;
    end else begin
      if (commit) begin
        rbr <= data;
        dr  <= 1'b1;
      end else if (bus.rbr_rd) begin
        dr  <= 1'b0;
      end
      oe <= (oe & ~bus.lsr_rd) | (commit & dr & ~bus.rbr_rd);
      pe <= (pe & ~bus.lsr_rd) | (commit & perr);
      fe <= (fe & ~bus.lsr_rd) | (commit & ~rxd_s);
      bi <= (bi & ~bus.lsr_rd) | (commit & brk);
    end
  end

  assign bus.rbr = rbr;
  assign bus.dr  = dr;
  assign bus.oe  = oe;
  assign bus.pe  = pe;
  assign bus.fe  = fe;
  assign bus.bi  = bi;

endmodule

// File: doc/uart_rx_16x.md
Name: uart_rx_16x

Overview:
- 8250-style UART receiver for the 8088 system, single clock domain on the 50 MHz system clock.
- Derives the 1.8432 MHz reference internally as a clock-enable, using a fractional accumulator. It does not generate a toggled clock.
- Divides the reference by the divisor latch value to get a 16x oversample tick, then deserialises rxd into an RBR-style holding register.
- Provides LSR-style status bits: dr, oe, pe, fe, bi.

Parameters:
- CNT_ADD, 576, accumulator step (576/15625 × 50 MHz = 1.8432 MHz exactly on average).
- CNT_MAX, 15625, accumulator modulus.
- SYNC_STAGES, 2, rxd synchroniser depth (at least 2).

Ports:
- clk_50m  in  1  50 MHz system clock.
- rst  in  1  reset. Asynchronous, active-high.
- divisor  in  16  divisor latch. Baud = 1.8432 MHz / (16 × divisor). 0 = receiver disabled.
- lcr_wls  in  2  word length: 0..3 gives 5..8 bits.
- lcr_pen  in  1  parity enable.
- lcr_eps  in  1  1 = even parity, 0 = odd.
- rxd  in  1  asynchronous serial input, idle high.
- rbr_rd  in  1  one-cycle strobe: CPU read of RBR.
- lsr_rd  in  1  one-cycle strobe: CPU read of LSR.
- rbr  out  8  received character. Unused upper bits are 0.
- dr  out  1  data ready.
- oe  out  1  overrun error.
- pe  out  1  parity error.
- fe  out  1  framing error.
- bi  out  1  break interrupt.

Behaviour:
- Reset (async, rst=1):
  - acc=0, divisor counter=0, state=IDLE, synchroniser=all 1.
  - rbr=0x00; dr, oe, pe, fe, bi = 0.
- Reference tick:
  - If acc >= CNT_MAX-CNT_ADD: acc <= acc+CNT_ADD-CNT_MAX and ref_tick=1 for that cycle.
  - Else acc <= acc+CNT_ADD.
  - acc is 15 bits. Exactly 576 ref_ticks per 15625 clocks.
- 16x tick:
  - On ref_tick the down-counter decrements. When it reaches 1, it reloads from divisor and s_tick pulses for one cycle.
  - A divisor change takes effect at the next reload.
  - divisor=0: no s_tick; counter held at 0; FSM forced to IDLE. A partial frame is discarded and status bits are untouched.
- rxd passes through the SYNC_STAGES synchroniser (rxd_s) before any use.
- FSM (sample counter cnt is 4 bits, advances on s_tick only):
  - IDLE: when rxd_s=0, go to START with cnt=0.
  - START: when cnt=7 and s_tick, check rxd_s. If 0, go to DATA with cnt=0 and bitcnt=0. If 1 (glitch), go back to IDLE with no status change.
  - DATA: when cnt=15 and s_tick, shift rxd_s in LSB-first. After 5+lcr_wls bits, go to PARITY if lcr_pen, else STOP.
  - PARITY: when cnt=15 and s_tick, capture the parity bit. perr = (^data ^ pbit) != (lcr_eps ? 0 : 1).
  - STOP: when cnt=15 and s_tick, commit the frame. Next state is WAIT_HIGH if the break condition holds, else IDLE.
  - WAIT_HIGH: when rxd_s=1, go to IDLE. A held-low line yields exactly one commit.
- Commit, effective on the cycle after the commit s_tick (1-cycle latency to dr):
  - rbr <= data, zero-extended.
  - dr <= 1.
  - fe |= ~stop.
  - pe |= perr.
  - bi |= (data, parity and stop all 0).
  - oe |= (dr was 1 and rbr_rd not asserted that cycle).
  - On overrun the new character overwrites rbr.
- Clears:
  - rbr_rd clears dr next cycle.
  - lsr_rd clears oe, pe, fe, bi next cycle.
- Simultaneous events:
  - Commit plus rbr_rd: dr stays 1, oe not set.
  - Commit plus lsr_rd: error bits take the new frame's values; old errors are cleared.
  - rbr_rd with dr=0: no effect.
- Reset mid-frame: everything returns to reset values immediately. No partial commit.

Decomposition:
- Package uart_pkg holds:
  - CNT_ADD, CNT_MAX.
  - The rx state encoding: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - LCR field widths and the WLS-to-bit-count mapping.
- Sub-module uart_baud_tick holds the fractional accumulator and divisor counter and outputs s_tick. It is shared with the future transmitter.

Test Plan:
- Reset, then divisor=1 for 15625 clocks → ref_tick count = 576 exactly. s_tick spacing is 27 or 28 clocks. All outputs at reset values.
- divisor=1, wls=3, pen=0; send 0xA5 at 115200 baud (434.03 clocks/bit) → rbr=0xA5, dr=1, pe=fe=bi=oe=0. rbr_rd → dr=0.
- divisor=12 (9600 baud), wls=2, pen=1, eps=1; send 0x41 with the parity bit forced to 1 → rbr=0x41, pe=1. lsr_rd → pe=0.
- Stop bit driven 0 with data 0x3C → fe=1, bi=0. Then rxd held low for 20 bit times → bi=1, fe=1, rbr=0x00, exactly one dr assertion. No further commit until rxd returns high.
- Two 8N1 characters 0x11 then 0x22 with no rbr_rd → rbr=0x22, oe=1. Repeat with rbr_rd coincident with the second commit → dr=1, oe=0.
- Low glitch of 4 s_ticks on rxd → no commit, FSM returns to IDLE. Assert rst halfway through the data bits of a 0x55 frame → dr=0, rbr=0x00. The next full frame 0x55 is received correctly.
